map_explore_engine: RTL



---
 rtl/map_explore_engine_pkg.sv | 35 +++
 rtl/map_explore_engine_if.sv | 30 +++
 rtl/map_explore_engine_reveal_scanner.sv | 71 +++++++
 rtl/map_explore_engine.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/map_explore_engine_pkg.sv
// ---------------------------------------------------------------------------
// map_pkg: definitions shared by the exploration engine, its reveal scanner
// and the benches that drive them.
//   - 3-bit tile codes stored in the map and reported on the display port
//   - direction encoding carried by cmd_dir
//   - engine FSM state encoding
//   - idx(): linear cell index from a column/row pair
// ---------------------------------------------------------------------------
package map_pkg;

  localparam logic [2:0] TILE_UNKNOWN  = 3'd0;
  localparam logic [2:0] TILE_CURRENT  = 3'd1;
  localparam logic [2:0] TILE_ENTRANCE = 3'd2;
  localparam logic [2:0] TILE_EXIT     = 3'd3;
  localparam logic [2:0] TILE_BLANK    = 3'd4;
  localparam logic [2:0] TILE_WALL     = 3'd5;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE_E   = 2'd0,
    ST_CHECK_E  = 2'd1,
    ST_REVEAL_E = 2'd2
  } state_e;

  function automatic int idx(input int x, input int y, input int w);
    return y * w + x;
  endfunction

endpackage

// File: rtl/map_explore_engine_if.sv
// ---------------------------------------------------------------------------
// map_explore_engine_if: command handshake, tile write port and display read
// port of the exploration engine.
//   cmd_valid/cmd_ready/cmd_dir : direction command handshake
//   tile_we/tile_addr/tile_wdata: tile map write strobe, index and code
//   rd_addr/rd_data             : combinational display read
// master = command/display client, slave = engine.
// ---------------------------------------------------------------------------
interface map_explore_engine_if #(
  parameter int AW = 7
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_dir;
  logic          tile_we;
  logic [AW-1:0] tile_addr;
  logic [2:0]    tile_wdata;
  logic [AW-1:0] rd_addr;
  logic [2:0]    rd_data;

  modport master (
    output cmd_valid, cmd_dir, tile_we, tile_addr, tile_wdata, rd_addr,
    input  cmd_ready, rd_data
  );

  modport slave (
    input  cmd_valid, cmd_dir, tile_we, tile_addr, tile_wdata, rd_addr,
    output cmd_ready, rd_data
  );
endinterface

// File: rtl/map_explore_engine_reveal_scanner.sv
// ---------------------------------------------------------------------------
// reveal_scanner: walks the (2R+1)x(2R+1) square around the player, one
// candidate per enabled cycle, and flags the candidates that lie on the grid
// and inside the Manhattan radius.
//   clk, rst_n   : clock, asynchronous active-low reset (counter back to 0)
//   en           : advance the scan this cycle
//   pos_x, pos_y : player position the offsets are applied to
//   cell_idx     : linear index of the current candidate (valid when hit)
//   hit          : candidate is on-grid and within the radius
//   last         : current candidate is the final one; counter wraps to 0
// ---------------------------------------------------------------------------
module reveal_scanner #(
  parameter int MAP_W    = 10,
  parameter int MAP_H    = 10,
  parameter int REVEAL_R = 2,
  parameter int AW       = 7,
  parameter int XW       = 4,
  parameter int YW       = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [XW-1:0] pos_x,
  input  logic [YW-1:0] pos_y,
  output logic [AW-1:0] cell_idx,
  output logic          hit,
  output logic          last
);
  localparam int D  = 2 * REVEAL_R + 1;
  localparam int KW = $clog2(D);
  localparam int CW = 16;

  // k is kept as its column/row split (k%D, k/D) so no divider is needed
  logic [KW-1:0] kx, ky;
  logic signed [CW-1:0] dx, dy, adx, ady, cx, cy, lin;
  logic in_grid, in_rad;

  assign last = (int'(kx) == D - 1) && (int'(ky) == D - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kx <= '0;
      ky <= '0;
    end else if (en) begin
      if (int'(kx) == D - 1) begin
        kx <= '0;
        ky <= last ? '0 : ky + KW'(1);
      end else begin
        kx <= kx + KW'(1);
      end
    end
  end

  always_comb begin
    dx  = $signed(CW'(kx)) - $signed(CW'(REVEAL_R));
    dy  = $signed(CW'(ky)) - $signed(CW'(REVEAL_R));
    adx = dx[CW-1] ? -dx : dx;
    ady = dy[CW-1] ? -dy : dy;
    cx  = $signed(CW'(pos_x)) + dx;
    cy  = $signed(CW'(pos_y)) + dy;
    // bounds are checked per axis, so a column offset can never wrap rows
    in_grid = !cx[CW-1] && (cx < $signed(CW'(MAP_W))) &&
              !cy[CW-1] && (cy < $signed(CW'(MAP_H)));
    in_rad  = (adx + ady) <= $signed(CW'(REVEAL_R));
    lin     = cy * $signed(CW'(MAP_W)) + cx;
  end

  assign hit      = in_grid && in_rad;
  assign cell_idx = AW'(lin);

endmodule

// File: rtl/map_explore_engine.sv
// ---------------------------------------------------------------------------
// map_explore_engine: tile map, fog-of-war bitmap and player position for a
// MAP_W x MAP_H exploration map.
//   clk, rst_n         : clock, asynchronous active-low reset
//   bus (slave)        : command handshake, tile writes, display read port
//   pos_x, pos_y       : player column / row
//   at_exit            : player stands on EXIT_POS (commands stop for good)
//   blocked            : one-cycle pulse after a rejected move
//   move_count         : accepted moves, saturating at 0xFFFF
// A command is checked for one cycle (CHECK); a legal move then reveals the
// Manhattan neighbourhood one candidate per cycle (REVEAL) before the next
// command is taken.
// ---------------------------------------------------------------------------
module map_explore_engine
  import map_pkg::*;
#(
  parameter  int MAP_W     = 10,
  parameter  int MAP_H     = 10,
  parameter  int REVEAL_R  = 2,
  parameter  int START_POS = 50,
  parameter  int EXIT_POS  = 59,
  localparam int AW        = $clog2(MAP_W * MAP_H),
  localparam int XW        = $clog2(MAP_W),
  localparam int YW        = $clog2(MAP_H)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  map_explore_engine_if.slave  bus,
  output logic [XW-1:0]        pos_x,
  output logic [YW-1:0]        pos_y,
  output logic                 at_exit,
  output logic                 blocked,
  output logic [15:0]          move_count
);
  localparam int N = MAP_W * MAP_H;
  localparam logic [XW-1:0] START_X = XW'(START_POS % MAP_W);
  localparam logic [YW-1:0] START_Y = YW'(START_POS / MAP_W);
  localparam logic START_AT_EXIT = 1'(START_POS == EXIT_POS);

  localparam logic [1:0] ST_IDLE   = ST_IDLE_E;
  localparam logic [1:0] ST_CHECK  = ST_CHECK_E;
  localparam logic [1:0] ST_REVEAL = ST_REVEAL_E;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [1:0]    state;
  dir_e          dir_q;
  logic [2:0]    tiles [N];
  logic [N-1:0]  revealed;
  logic [AW-1:0] pos_idx;
  logic          hs, tile_wr_ok;
  logic          tgt_ok, legal;
  logic [XW-1:0] tgt_x;
  logic [YW-1:0] tgt_y;
  logic [AW-1:0] tgt_idx;
  logic          scan_en, scan_hit, scan_last;
  logic [AW-1:0] scan_idx;
  logic [2:0]    rd_code;

  assign pos_idx       = AW'(idx(int'(pos_x), int'(pos_y), MAP_W));
  assign bus.cmd_ready = (state == ST_IDLE) && !at_exit;
  assign hs            = bus.cmd_valid && bus.cmd_ready;
  assign scan_en       = (state == ST_REVEAL);
  // the player's own cell is never overwritten; writes land before CHECK
  assign tile_wr_ok    = (state == ST_IDLE) && bus.tile_we &&
                         (int'(bus.tile_addr) < N) && (bus.tile_addr != pos_idx);

  always_comb begin
    tgt_ok = 1'b0;
    tgt_x  = pos_x;
    tgt_y  = pos_y;
    case (dir_q)
      DIR_UP:    if (pos_y != '0)             begin tgt_ok = 1'b1; tgt_y = pos_y - YW'(1); end
      DIR_DOWN:  if (int'(pos_y) != MAP_H - 1) begin tgt_ok = 1'b1; tgt_y = pos_y + YW'(1); end
      DIR_LEFT:  if (pos_x != '0)             begin tgt_ok = 1'b1; tgt_x = pos_x - XW'(1); end
      DIR_RIGHT: if (int'(pos_x) != MAP_W - 1) begin tgt_ok = 1'b1; tgt_x = pos_x + XW'(1); end
      default: ;
    endcase
    tgt_idx = AW'(idx(int'(tgt_x), int'(tgt_y), MAP_W));
    legal   = tgt_ok && (tiles[tgt_idx] != TILE_WALL);
  end

  reveal_scanner #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .REVEAL_R(REVEAL_R),
    .AW(AW), .XW(XW), .YW(YW)
  ) u_scan (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (scan_en),
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .cell_idx (scan_idx),
    .hit      (scan_hit),
    .last     (scan_last)
  );

  // reset lands in REVEAL so the entrance neighbourhood is uncovered first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_REVEAL;
      dir_q      <= DIR_UP;
      pos_x      <= START_X;
      pos_y      <= START_Y;
      at_exit    <= START_AT_EXIT;
      blocked    <= 1'b0;
      move_count <= '0;
    end else begin
      blocked <= 1'b0;
      case (state)
        ST_IDLE: if (hs) begin
          dir_q <= dir_e'(bus.cmd_dir);
          state <= ST_CHECK;
        end
        ST_CHECK: if (legal) begin
          pos_x      <= tgt_x;
          pos_y      <= tgt_y;
          at_exit    <= (int'(tgt_idx) == EXIT_POS);
          move_count <= sat_inc(move_count);
          state      <= ST_REVEAL;
        end else begin
          blocked <= 1'b1;
          state   <= ST_IDLE;
        end
        ST_REVEAL: if (scan_last) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) tiles[i] <= TILE_BLANK;
      tiles[START_POS] <= TILE_ENTRANCE;
      tiles[EXIT_POS]  <= TILE_EXIT;
    end else if (tile_wr_ok) begin
      tiles[bus.tile_addr] <= bus.tile_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) revealed <= '0;
    else if (scan_en && scan_hit) revealed[scan_idx] <= 1'b1;
  end

  always_comb begin
    rd_code = TILE_UNKNOWN;
    if (int'(bus.rd_addr) < N) begin
      if (bus.rd_addr == pos_idx)      rd_code = TILE_CURRENT;
      else if (revealed[bus.rd_addr])  rd_code = tiles[bus.rd_addr];
    end
  end
  assign bus.rd_data = rd_code;

endmodule
